memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 14 +
 rtl/dmem_timer.sv | 34 +++
 rtl/memory_access.sv | 182 ++++++++++++++++++
 tb/tb_memory_access.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Pipeline constants shared by every stage: the MEM-stage FSM encoding and
//   the default bus timeout in cycles.
package memory_access_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ma_state_t;

    // BUSY cycles without dm_ack before an access is abandoned.
    localparam int TIMEOUT_DEFAULT = 16;

endpackage : memory_access_pkg

// File: rtl/dmem_timer.sv
// dmem_timer
//   Wait counter for an outstanding data-memory access.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, clears the count
//   clr     : clear the count (held while the FSM is idle)
//   en      : count this cycle (busy and no acknowledge)
//   expired : combinational, high in the counting cycle that reaches TIMEOUT-1
module dmem_timer #(
    parameter int TIMEOUT = memory_access_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // Because en already excludes dm_ack, an acknowledge in the final cycle
    // wins over the timeout.
    assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule : dmem_timer

// File: rtl/memory_access.sv
// memory_access
//   MEM stage of the pipeline. Issues one data-memory request per aligned
//   load/store, freezes upstream while it is outstanding, and fills the
//   MEM/WB register. Misaligned accesses and bus timeouts become bubbles
//   with a one-cycle error pulse.
//
//   clk, rst                      : clock, synchronous active-high reset
//   XM_*, ALUout                  : EX/MEM register (held stable while stall=1)
//   dm_req/dm_we/dm_addr/dm_wdata : data-memory request
//   dm_rdata, dm_ack              : data-memory response
//   MW_*                          : MEM/WB register
//   stall                         : freeze upstream stages
//   branch_taken, branch_target   : pass-through of the resolved branch
//   align_err, bus_err            : one-cycle error pulses
//   dbg_state                     : current FSM state
//
// Memory handshake: dm_req stays high for every BUSY cycle with dm_we,
// dm_addr and dm_wdata stable; the memory completes by raising dm_ack for
// one cycle, and the transfer happens on that clock edge. dm_ack outside
// BUSY carries no meaning and is ignored.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        XM_MemtoReg,
    input  logic        XM_RegWrite,
    input  logic        XM_MemRead,
    input  logic        XM_MemWrite,
    input  logic        XM_branch,
    input  logic [4:0]  XM_RD,
    input  logic [31:0] ALUout,
    input  logic [31:0] XM_MD,
    input  logic [31:0] XM_BT,

    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,

    output logic        MW_MemtoReg,
    output logic        MW_RegWrite,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_MDR,

    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        align_err,
    output logic        bus_err,

    output ma_state_t   dbg_state
);

    ma_state_t state, state_next;

    logic mem_op;
    logic aligned;
    logic start_access;   // aligned request seen in IDLE
    logic misaligned;     // misaligned request seen in IDLE
    logic timer_en;
    logic timer_clr;
    logic expired;
    logic load_done;      // acknowledged load: capture read data

    assign mem_op  = XM_MemRead | XM_MemWrite;
    assign aligned = (ALUout[1:0] == 2'b00);

    // Branch resolution bypasses the FSM entirely.
    assign branch_taken  = XM_branch;
    assign branch_target = XM_BT;

    // Address and data come straight from EX/MEM, which upstream holds while
    // stalled, so nothing is latched here.
    assign dm_addr  = ALUout;
    assign dm_wdata = XM_MD;

    assign dbg_state = state;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dm_ack || expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        start_access = 1'b0;
        misaligned   = 1'b0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        stall        = 1'b0;
        timer_en     = 1'b0;
        timer_clr    = 1'b0;
        load_done    = 1'b0;
        unique case (state)
            IDLE: begin
                timer_clr    = 1'b1;
                start_access = !rst && mem_op && aligned;
                misaligned   = !rst && mem_op && !aligned;
                stall        = start_access;
            end
            BUSY: begin
                dm_req    = !rst;
                dm_we     = !rst && XM_MemWrite;
                timer_en  = !rst && !dm_ack;
                // expired is only high with timer_en, so no stall in the
                // timeout cycle either.
                stall     = !rst && !dm_ack && !expired;
                load_done = !rst && dm_ack && XM_MemRead;
            end
            default: ;
        endcase
    end

    dmem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    // --------------------------------------------------- MEM/WB and errors
    always_ff @(posedge clk) begin
        if (rst) begin
            MW_MemtoReg <= 1'b0;
            MW_RegWrite <= 1'b0;
            MW_RD       <= '0;
            MW_ALUout   <= '0;
            MW_MDR      <= '0;
            align_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            align_err <= misaligned;
            bus_err   <= expired;
            if (stall || misaligned || expired) begin
                // Bubble: nothing may be written back for this slot.
                MW_MemtoReg <= 1'b0;
                MW_RegWrite <= 1'b0;
            end else begin
                MW_MemtoReg <= XM_MemtoReg;
                MW_RegWrite <= XM_RegWrite;
                MW_RD       <= XM_RD;
                MW_ALUout   <= ALUout;
                if (load_done) begin
                    MW_MDR <= dm_rdata;
                end
            end
        end
    end

endmodule : memory_access

// File: tb/tb_memory_access.sv
// tb_memory_access
//   Directed bench for the MEM stage: reset, branch pass-through, load with
//   wait states, store, misaligned access, timeout, late ack and reset abort.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk;
    logic        rst;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
    logic [4:0]  XM_RD;
    logic [31:0] ALUout, XM_MD, XM_BT;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        MW_MemtoReg, MW_RegWrite;
    logic [4:0]  MW_RD;
    logic [31:0] MW_ALUout, MW_MDR;
    logic        stall, branch_taken, align_err, bus_err;
    logic [31:0] branch_target;
    ma_state_t   dbg_state;

    int checks   = 0;
    int failures = 0;

    memory_access dut (
        .clk           (clk),
        .rst           (rst),
        .XM_MemtoReg   (XM_MemtoReg),
        .XM_RegWrite   (XM_RegWrite),
        .XM_MemRead    (XM_MemRead),
        .XM_MemWrite   (XM_MemWrite),
        .XM_branch     (XM_branch),
        .XM_RD         (XM_RD),
        .ALUout        (ALUout),
        .XM_MD         (XM_MD),
        .XM_BT         (XM_BT),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack),
        .MW_MemtoReg   (MW_MemtoReg),
        .MW_RegWrite   (MW_RegWrite),
        .MW_RD         (MW_RD),
        .MW_ALUout     (MW_ALUout),
        .MW_MDR        (MW_MDR),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .align_err     (align_err),
        .bus_err       (bus_err),
        .dbg_state     (dbg_state)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        XM_MemtoReg = 1'b0;
        XM_RegWrite = 1'b0;
        XM_MemRead  = 1'b0;
        XM_MemWrite = 1'b0;
        XM_branch   = 1'b0;
        XM_RD       = 5'd0;
        ALUout      = 32'h0;
        XM_MD       = 32'h0;
        XM_BT       = 32'h0;
        dm_ack      = 1'b0;
        dm_rdata    = 32'h0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
        drive_nop();
        XM_MemRead  = 1'b1;
        XM_MemtoReg = 1'b1;
        XM_RegWrite = 1'b1;
        XM_RD       = rd;
        ALUout      = addr;
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        drive_nop();
        rst = 1'b1;
        tick();
        // A load presented during reset must not stall or request.
        drive_load(32'h10, 5'd3);
        settle();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dm_req", 32'(dm_req), 32'd0);
        tick();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_mw_regwrite", 32'(MW_RegWrite), 32'd0);
        check("rst_mw_memtoreg", 32'(MW_MemtoReg), 32'd0);
        check("rst_mw_rd", 32'(MW_RD), 32'd0);
        check("rst_mw_aluout", MW_ALUout, 32'h0);
        check("rst_mw_mdr", MW_MDR, 32'h0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);

        // Branch pass-through plus plain ALU result into MW.
        rst = 1'b0;
        drive_nop();
        XM_branch   = 1'b1;
        XM_BT       = 32'h400;
        XM_RegWrite = 1'b1;
        XM_RD       = 5'd5;
        ALUout      = 32'h99;
        settle();
        check("br_taken", 32'(branch_taken), 32'd1);
        check("br_target", branch_target, 32'h400);
        check("br_stall", 32'(stall), 32'd0);
        tick();
        check("alu_mw_regwrite", 32'(MW_RegWrite), 32'd1);
        check("alu_mw_rd", 32'(MW_RD), 32'd5);
        check("alu_mw_aluout", MW_ALUout, 32'h99);
        check("alu_mw_mdr", MW_MDR, 32'h0);

        // Load at 0x10, acked in the 3rd BUSY cycle.
        drive_load(32'h10, 5'd7);
        settle();
        check("ld_idle_stall", 32'(stall), 32'd1);
        check("ld_idle_req", 32'(dm_req), 32'd0);
        tick();
        check("ld_b1_state", 32'(dbg_state), 32'(BUSY));
        check("ld_b1_bubble", 32'(MW_RegWrite), 32'd0);
        check("ld_b1_req", 32'(dm_req), 32'd1);
        check("ld_b1_we", 32'(dm_we), 32'd0);
        check("ld_b1_addr", dm_addr, 32'h10);
        check("ld_b1_stall", 32'(stall), 32'd1);
        tick();
        check("ld_b2_stall", 32'(stall), 32'd1);
        check("ld_b2_req", 32'(dm_req), 32'd1);
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        settle();
        check("ld_b3_stall", 32'(stall), 32'd0);
        tick();
        check("ld_mw_mdr", MW_MDR, 32'hDEADBEEF);
        check("ld_mw_regwrite", 32'(MW_RegWrite), 32'd1);
        check("ld_mw_memtoreg", 32'(MW_MemtoReg), 32'd1);
        check("ld_mw_rd", 32'(MW_RD), 32'd7);
        check("ld_mw_aluout", MW_ALUout, 32'h10);
        check("ld_done_state", 32'(dbg_state), 32'(IDLE));

        // Stray ack while idle must not touch MW_MDR.
        drive_nop();
        XM_RegWrite = 1'b1;
        XM_RD       = 5'd2;
        dm_ack      = 1'b1;
        dm_rdata    = 32'h00000BAD;
        tick();
        check("idle_ack_mdr", MW_MDR, 32'hDEADBEEF);
        check("idle_ack_state", 32'(dbg_state), 32'(IDLE));

        // Store at 0x20, acked in the 1st BUSY cycle.
        drive_nop();
        XM_MemWrite = 1'b1;
        ALUout      = 32'h20;
        XM_MD       = 32'h12345678;
        settle();
        check("st_idle_stall", 32'(stall), 32'd1);
        tick();
        check("st_req", 32'(dm_req), 32'd1);
        check("st_we", 32'(dm_we), 32'd1);
        check("st_addr", dm_addr, 32'h20);
        check("st_wdata", dm_wdata, 32'h12345678);
        dm_ack   = 1'b1;
        dm_rdata = 32'h55555555;
        settle();
        check("st_ack_stall", 32'(stall), 32'd0);
        tick();
        check("st_state", 32'(dbg_state), 32'(IDLE));
        check("st_mw_mdr", MW_MDR, 32'hDEADBEEF);
        check("st_mw_aluout", MW_ALUout, 32'h20);

        // Misaligned load at 0x13.
        drive_load(32'h13, 5'd4);
        settle();
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_req", 32'(dm_req), 32'd0);
        tick();
        check("mis_align_err", 32'(align_err), 32'd1);
        check("mis_mw_regwrite", 32'(MW_RegWrite), 32'd0);
        check("mis_req_after", 32'(dm_req), 32'd0);
        check("mis_state", 32'(dbg_state), 32'(IDLE));
        drive_nop();
        tick();
        check("mis_align_err_drop", 32'(align_err), 32'd0);

        // Load with no ack: timeout after 16 BUSY cycles.
        drive_load(32'h40, 5'd6);
        tick();
        for (int i = 1; i <= 15; i++) begin
            check("to_wait_stall", 32'(stall), 32'd1);
            check("to_wait_bus_err", 32'(bus_err), 32'd0);
            tick();
        end
        check("to_last_req", 32'(dm_req), 32'd1);
        check("to_last_stall", 32'(stall), 32'd0);
        tick();
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_mw_regwrite", 32'(MW_RegWrite), 32'd0);
        check("to_state", 32'(dbg_state), 32'(IDLE));
        drive_nop();
        tick();
        check("to_bus_err_drop", 32'(bus_err), 32'd0);

        // Load acked in the 16th BUSY cycle: ack wins over the timeout.
        drive_load(32'h44, 5'd9);
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        dm_ack   = 1'b1;
        dm_rdata = 32'hCAFEF00D;
        settle();
        check("late_stall", 32'(stall), 32'd0);
        tick();
        check("late_bus_err", 32'(bus_err), 32'd0);
        check("late_mw_mdr", MW_MDR, 32'hCAFEF00D);
        check("late_mw_regwrite", 32'(MW_RegWrite), 32'd1);
        check("late_mw_rd", 32'(MW_RD), 32'd9);

        // Reset in the 2nd BUSY cycle aborts the access.
        drive_load(32'h50, 5'd10);
        tick();
        tick();
        check("abort_b2_req", 32'(dm_req), 32'd1);
        rst = 1'b1;
        settle();
        check("abort_rst_req", 32'(dm_req), 32'd0);
        check("abort_rst_stall", 32'(stall), 32'd0);
        tick();
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_mw_mdr", MW_MDR, 32'h0);
        check("abort_mw_aluout", MW_ALUout, 32'h0);
        check("abort_mw_rd", 32'(MW_RD), 32'd0);
        check("abort_mw_regwrite", 32'(MW_RegWrite), 32'd0);
        rst = 1'b0;
        drive_nop();
        dm_ack   = 1'b1;
        dm_rdata = 32'h11111111;
        tick();
        check("abort_late_ack_mdr", MW_MDR, 32'h0);
        check("abort_late_ack_req", 32'(dm_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_access
